// File: rtl/spi_frame_sequencer.sv
// Frame sequencer: pulls iLEN rows from the input FIFO into the BNN, then moves
// oLEN results (zero-padded on watchdog expiry) into the output FIFO.
module spi_frame_sequencer #(
    parameter int iWL    = 96,
    parameter int iLEN   = 180,
    parameter int oWL    = 13,
    parameter int oLEN   = 5,
    parameter int WL_ROW = 8,
    parameter int WL_RES = 3,
    parameter int TO_CYC = 65535
) (
    input  logic              clk,
    input  logic              iRST,
    input  logic              iWRFULL,
    input  logic              iRDEMPTY,
    output logic              oRDEN,
    output logic              oROW_VALID,
    output logic [WL_ROW-1:0] oROW_IDX,
    output logic              oROW_LAST,
    output logic              oBNN_START,
    input  logic              iRES_VALID,
    input  logic [oWL-1:0]    iRES_DATA,
    output logic [oWL-1:0]    oDATA,
    output logic              oWREN,
    output logic              oFINISH,
    output logic              oBUSY,
    output logic              oOVERRUN,
    output logic              oTIMEOUT,
    output logic [7:0]        oFRAME_CNT
);
    // state   | meaning
    // IDLE    | waiting for a loaded frame
    // LOAD    | reading rows out of the input FIFO
    // START   | last row on the bus, BNN start pulse armed
    // COLLECT | capturing BNN results, watchdog running
    // PAD     | watchdog expired, filling remaining words with zero
    // DONE    | all words written, finish pulse armed
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_COLLECT, S_PAD, S_DONE
    } state_t;

    if (iWL < 1 || iLEN < 1 || iLEN > (1 << WL_ROW) - 1 ||
        oLEN < 1 || oLEN > (1 << WL_RES) - 1) begin : g_cfg_check
        $error("spi_frame_sequencer: counter widths too small for iLEN/oLEN");
    end

    localparam logic [WL_ROW-1:0] ROW_LEN  = WL_ROW'(iLEN);
    localparam logic [WL_ROW-1:0] ROW_LAST = WL_ROW'(iLEN - 1);
    localparam logic [WL_RES-1:0] RES_LAST = WL_RES'(oLEN - 1);
    localparam logic [15:0]       WD_LAST  = 16'(TO_CYC - 1);

    state_t              state, state_nx;
    logic [WL_ROW-1:0]   rd_cnt;
    logic [WL_RES-1:0]   res_cnt;
    logic [15:0]         wd_cnt;
    logic                rden;

    always_comb begin
        state_nx = state;
        rden     = 1'b0;
        case (state)
            S_IDLE:    if (iWRFULL) state_nx = S_LOAD;
            S_LOAD: begin
                rden = ~iRDEMPTY & (rd_cnt < ROW_LEN);
                if (rden && rd_cnt == ROW_LAST) state_nx = S_START;
            end
            S_START:   state_nx = S_COLLECT;
            S_COLLECT: begin
                // a result arriving on the watchdog's last cycle still counts
                if (iRES_VALID) begin
                    if (res_cnt == RES_LAST) state_nx = S_DONE;
                end else if (wd_cnt == WD_LAST) begin
                    state_nx = S_PAD;
                end
            end
            S_PAD:     if (res_cnt == RES_LAST) state_nx = S_DONE;
            S_DONE:    state_nx = iWRFULL ? S_LOAD : S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    assign oRDEN = rden;
    assign oBUSY = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (iRST) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            res_cnt    <= '0;
            wd_cnt     <= '0;
            oROW_VALID <= 1'b0;
            oROW_IDX   <= '0;
            oROW_LAST  <= 1'b0;
            oBNN_START <= 1'b0;
            oDATA      <= '0;
            oWREN      <= 1'b0;
            oFINISH    <= 1'b0;
            oOVERRUN   <= 1'b0;
            oTIMEOUT   <= 1'b0;
            oFRAME_CNT <= '0;
        end else begin
            state      <= state_nx;
            oROW_VALID <= rden;
            oROW_IDX   <= rd_cnt;
            oROW_LAST  <= rden & (rd_cnt == ROW_LAST);
            oBNN_START <= (state == S_START);
            oFINISH    <= (state == S_DONE);
            oWREN      <= 1'b0;

            if ((state == S_IDLE || state == S_DONE) && iWRFULL) rd_cnt <= '0;
            else if (rden) rd_cnt <= rd_cnt + 1'b1;

            if (state == S_START) begin
                res_cnt <= '0;
                wd_cnt  <= '0;
            end

            if (state == S_COLLECT) begin
                if (iRES_VALID) begin
                    res_cnt <= res_cnt + 1'b1;
                    wd_cnt  <= '0;
                    oWREN   <= 1'b1;
                    oDATA   <= iRES_DATA;
                end else begin
                    wd_cnt <= wd_cnt + 16'd1;
                    if (wd_cnt == WD_LAST) oTIMEOUT <= 1'b1;
                end
            end

            if (state == S_PAD) begin
                res_cnt <= res_cnt + 1'b1;
                oWREN   <= 1'b1;
                oDATA   <= '0;
            end

            if (state == S_DONE) oFRAME_CNT <= oFRAME_CNT + 8'd1;

            // a second frame while busy is dropped, only flagged
            if (iWRFULL && (state == S_LOAD || state == S_START ||
                            state == S_COLLECT || state == S_PAD))
                oOVERRUN <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Bench for spi_frame_sequencer: frame-level vector table plus directed
// reset, spurious-input and frame-counter wrap sequences.
module tb_spi_frame_sequencer;
    localparam int ILEN = 180;
    localparam int OLEN = 5;
    localparam int OWL  = 13;
    localparam int TO   = 16;

    logic           clk = 1'b0;
    logic           iRST, iWRFULL, iRDEMPTY, iRES_VALID;
    logic [OWL-1:0] iRES_DATA;
    logic           oRDEN, oROW_VALID, oROW_LAST, oBNN_START;
    logic [7:0]     oROW_IDX;
    logic [OWL-1:0] oDATA;
    logic           oWREN, oFINISH, oBUSY, oOVERRUN, oTIMEOUT;
    logic [7:0]     oFRAME_CNT;

    always #5 clk = ~clk;

    spi_frame_sequencer #(
        .iWL(96), .iLEN(ILEN), .oWL(OWL), .oLEN(OLEN),
        .WL_ROW(8), .WL_RES(3), .TO_CYC(TO)
    ) dut (
        .clk(clk), .iRST(iRST), .iWRFULL(iWRFULL), .iRDEMPTY(iRDEMPTY),
        .oRDEN(oRDEN), .oROW_VALID(oROW_VALID), .oROW_IDX(oROW_IDX),
        .oROW_LAST(oROW_LAST), .oBNN_START(oBNN_START),
        .iRES_VALID(iRES_VALID), .iRES_DATA(iRES_DATA),
        .oDATA(oDATA), .oWREN(oWREN), .oFINISH(oFINISH), .oBUSY(oBUSY),
        .oOVERRUN(oOVERRUN), .oTIMEOUT(oTIMEOUT), .oFRAME_CNT(oFRAME_CNT)
    );

    typedef struct {
        bit                      start, stall, b2b, spur;
        int                      ovr_at, gap, nres;
        logic [4:0][OWL-1:0]     din, dexp;
        bit                      to, ovr;
        logic [7:0]              fcnt;
    } vec_t;

    vec_t vq[$];
    int   total = 0, bad = 0;
    int   cyc = 0;

    int   n_rden, n_rows, n_last, idx_err, stall_err, bnn_gap, last_rden_cyc, last_wr_cyc;
    logic [7:0]     exp_idx;
    logic [OWL-1:0] wq[$];
    int   d_rden, d_rows, d_last, d_idx_err, d_stall, d_bnn_gap, d_fin_gap;
    logic [OWL-1:0] d_wq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        n_rden = 0; n_rows = 0; n_last = 0; idx_err = 0; stall_err = 0;
        bnn_gap = -1; exp_idx = '0; wq.delete();
    endtask

    // one clock: combinational read request seen before the edge, registered outputs after
    task automatic tick();
        #1;
        if (oRDEN) begin
            n_rden++;
            last_rden_cyc = cyc;
            if (iRDEMPTY) stall_err++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (oFINISH) begin
            d_rden = n_rden; d_rows = n_rows; d_last = n_last; d_idx_err = idx_err;
            d_stall = stall_err; d_bnn_gap = bnn_gap; d_fin_gap = cyc - last_wr_cyc;
            d_wq = wq;
            clear_mon();
        end
        if (oROW_VALID) begin
            n_rows++;
            if (oROW_IDX !== exp_idx) idx_err++;
            if (oROW_LAST !== (oROW_IDX == 8'(ILEN - 1))) idx_err++;
            if (oROW_LAST) n_last++;
            exp_idx++;
        end
        if (oBNN_START) bnn_gap = cyc - last_rden_cyc;
        if (oWREN) begin
            wq.push_back(oDATA);
            last_wr_cyc = cyc;
        end
    endtask

    function automatic vec_t mkv(input bit start, input bit stall, input bit b2b, input bit spur,
                                 input int ovr_at, input int gap, input int nres,
                                 input logic [4:0][OWL-1:0] din, input logic [4:0][OWL-1:0] dexp,
                                 input bit to, input bit ovr, input logic [7:0] fcnt);
        vec_t v;
        v.start = start; v.stall = stall; v.b2b = b2b; v.spur = spur;
        v.ovr_at = ovr_at; v.gap = gap; v.nres = nres;
        v.din = din; v.dexp = dexp; v.to = to; v.ovr = ovr; v.fcnt = fcnt;
        return v;
    endfunction

    task automatic run_frame(input int vi, input vec_t v);
        int n;
        if (v.start) begin
            clear_mon();
            iWRFULL = 1'b1; tick(); iWRFULL = 1'b0;
            chk($sformatf("v%0d_busy", vi), oBUSY, 1);
        end
        n = 0;
        while (!oBNN_START && n < 3000) begin
            iRDEMPTY   = v.stall ? 1'($urandom_range(0, 1)) : 1'b0;
            iWRFULL    = (v.ovr_at != 0 && n == v.ovr_at);
            iRES_VALID = v.spur;
            tick();
            n++;
        end
        iRDEMPTY = 1'b0; iWRFULL = 1'b0; iRES_VALID = 1'b0;
        chk($sformatf("v%0d_bnn_seen", vi), oBNN_START, 1);
        for (int i = 0; i < v.nres; i++) begin
            for (int g = 0; g < v.gap; g++) tick();
            iRES_VALID = 1'b1; iRES_DATA = v.din[i];
            tick();
            iRES_VALID = 1'b0;
        end
        if (v.nres < OLEN) begin
            n = 0;
            do begin tick(); n++; end while (!oWREN && n < 40);
            chk($sformatf("v%0d_pad_delay", vi), n, TO + 1);
        end
        if (v.b2b) begin
            iWRFULL = 1'b1; tick(); iWRFULL = 1'b0;
        end
        n = 0;
        while (!oFINISH && n < 300) begin tick(); n++; end
        chk($sformatf("v%0d_finish", vi), oFINISH, 1);
        chk($sformatf("v%0d_rden", vi), d_rden, ILEN);
        chk($sformatf("v%0d_rows", vi), d_rows, ILEN);
        chk($sformatf("v%0d_last", vi), d_last, 1);
        chk($sformatf("v%0d_idx_err", vi), d_idx_err, 0);
        chk($sformatf("v%0d_stall_err", vi), d_stall, 0);
        chk($sformatf("v%0d_bnn_gap", vi), d_bnn_gap, 2);
        chk($sformatf("v%0d_fin_gap", vi), d_fin_gap, 1);
        chk($sformatf("v%0d_nwords", vi), d_wq.size(), OLEN);
        for (int i = 0; i < OLEN && i < d_wq.size(); i++)
            chk($sformatf("v%0d_word%0d", vi, i), d_wq[i], v.dexp[i]);
        chk($sformatf("v%0d_data_hold", vi), oDATA, v.dexp[4]);
        chk($sformatf("v%0d_fcnt", vi), oFRAME_CNT, v.fcnt);
        chk($sformatf("v%0d_timeout", vi), oTIMEOUT, v.to);
        chk($sformatf("v%0d_overrun", vi), oOVERRUN, v.ovr);
        chk($sformatf("v%0d_busy_end", vi), oBUSY, v.b2b);
    endtask

    task automatic fast_frame(output bit ok);
        int n;
        iWRFULL = 1'b1; tick(); iWRFULL = 1'b0;
        n = 0;
        while (!oFINISH && n < 400) begin tick(); n++; end
        ok = oFINISH;
        chk("fast_finish", oFINISH, 1);
    endtask

    initial begin
        int  n;
        bit  ok;
        iRST = 1'b1; iWRFULL = 1'b0; iRDEMPTY = 1'b0; iRES_VALID = 1'b0; iRES_DATA = '0;
        clear_mon();
        last_rden_cyc = 0; last_wr_cyc = 0;

        //                start stall b2b spur ovr gap nres din / dexp                                               to ovr fcnt
        vq.push_back(mkv(1, 0, 0, 0, 0,  0, 5, {13'h5, 13'h4, 13'h3, 13'h2, 13'h1},
                                               {13'h5, 13'h4, 13'h3, 13'h2, 13'h1},           0, 0, 8'd1));
        vq.push_back(mkv(1, 1, 0, 0, 0,  0, 5, {13'h0123, 13'h0000, 13'h1555, 13'h0AAA, 13'h1FFF},
                                               {13'h0123, 13'h0000, 13'h1555, 13'h0AAA, 13'h1FFF}, 0, 0, 8'd2));
        vq.push_back(mkv(1, 0, 1, 0, 0, 15, 5, {13'h104, 13'h103, 13'h102, 13'h101, 13'h100},
                                               {13'h104, 13'h103, 13'h102, 13'h101, 13'h100}, 0, 0, 8'd3));
        vq.push_back(mkv(0, 0, 0, 0, 0,  0, 5, {13'h1000, 13'h0042, 13'h1234, 13'h0FEE, 13'h0BAD},
                                               {13'h1000, 13'h0042, 13'h1234, 13'h0FEE, 13'h0BAD}, 0, 0, 8'd4));
        vq.push_back(mkv(1, 0, 0, 0, 50, 0, 5, {13'h15, 13'h14, 13'h13, 13'h12, 13'h11},
                                               {13'h15, 13'h14, 13'h13, 13'h12, 13'h11},      0, 1, 8'd5));
        vq.push_back(mkv(1, 0, 0, 0, 0,  0, 2, {13'h0, 13'h0, 13'h0, 13'h8, 13'h7},
                                               {13'h0, 13'h0, 13'h0, 13'h8, 13'h7},           1, 1, 8'd6));
        vq.push_back(mkv(1, 0, 0, 0, 0,  0, 0, {13'h0, 13'h0, 13'h0, 13'h0, 13'h0},
                                               {13'h0, 13'h0, 13'h0, 13'h0, 13'h0},           1, 1, 8'd7));

        tick(); tick();
        chk("reset_outs", {oRDEN, oROW_VALID, oROW_IDX, oROW_LAST, oBNN_START, oDATA, oWREN,
                           oFINISH, oBUSY, oOVERRUN, oTIMEOUT, oFRAME_CNT}, 0);
        iRST = 1'b0;
        tick();

        for (int i = 0; i < vq.size(); i++) run_frame(i, vq[i]);

        // reset during COLLECT after three results
        clear_mon();
        iWRFULL = 1'b1; tick(); iWRFULL = 1'b0;
        n = 0;
        while (!oBNN_START && n < 1000) begin tick(); n++; end
        for (int i = 0; i < 3; i++) begin
            iRES_VALID = 1'b1; iRES_DATA = 13'(13'h0A0 + i); tick(); iRES_VALID = 1'b0;
        end
        chk("pre_rst_writes", wq.size(), 3);
        iRST = 1'b1; tick();
        chk("midop_rst_outs", {oRDEN, oROW_VALID, oROW_IDX, oROW_LAST, oBNN_START, oDATA, oWREN,
                               oFINISH, oBUSY, oOVERRUN, oTIMEOUT, oFRAME_CNT}, 0);
        iRST = 1'b0;
        wq.delete();
        for (int i = 0; i < 2; i++) begin
            iRES_VALID = 1'b1; iRES_DATA = 13'h1ABC; tick(); iRES_VALID = 1'b0; tick();
        end
        for (int i = 0; i < 20; i++) tick();
        chk("idle_spurious_wren", wq.size(), 0);
        chk("idle_after_rst", oBUSY, 0);

        run_frame(7, mkv(1, 0, 0, 1, 0, 0, 5, {13'h1E, 13'h1D, 13'h1C, 13'h1B, 13'h1A},
                                              {13'h1E, 13'h1D, 13'h1C, 13'h1B, 13'h1A}, 0, 0, 8'd1));

        // frame counter wrap: results held valid, ignored outside COLLECT
        iRES_VALID = 1'b1; iRES_DATA = '0;
        ok = 1'b1;
        for (int f = 0; f < 254 && ok; f++) fast_frame(ok);
        chk("fcnt_255", oFRAME_CNT, 255);
        if (ok) fast_frame(ok);
        chk("fcnt_wrap", oFRAME_CNT, 0);
        iRES_VALID = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
Sequences one inference frame through the SPI datapath on the FPGA clock domain. On the frame-loaded pulse from the SPI input side, it reads iLEN rows of iWL bits out of the input FIFO and streams them to the BNN front end (zero padding), then starts the BNN. It collects oLEN results of oWL bits and writes them into the output FIFO. Finally it pulses a finish strobe so the SPI side arms its MISO shifter.

Parameters:
iWL, 96, width of one input row (informational; sequencer does not touch row data)
iLEN, 180, rows per frame
oWL, 13, result word width
oLEN, 5, result words per frame
WL_ROW, 8, row index / row counter width (must hold iLEN)
WL_RES, 3, result counter width (must hold oLEN)
TO_CYC, 65535, collect-phase watchdog limit in clk cycles (16-bit counter)

Ports:
clk  in  1  FPGA clock; all logic on posedge
iRST  in  1  synchronous reset, active-high
iWRFULL  in  1  single-cycle pulse: full frame present in input FIFO
iRDEMPTY  in  1  input FIFO read-side empty flag
oRDEN  out  1  input FIFO read request
oROW_VALID  out  1  input FIFO q (row data) valid this cycle
oROW_IDX  out  WL_ROW  index 0..iLEN-1 of the valid row
oROW_LAST  out  1  high with oROW_VALID for row iLEN-1
oBNN_START  out  1  one-cycle pulse: all rows delivered, BNN may run
iRES_VALID  in  1  result word valid from BNN
iRES_DATA  in  oWL  result word
oDATA  out  oWL  word to output FIFO
oWREN  out  1  output FIFO write request
oFINISH  out  1  one-cycle pulse: frame results fully written
oBUSY  out  1  high in every state except IDLE
oOVERRUN  out  1  sticky: iWRFULL arrived while busy
oTIMEOUT  out  1  sticky: watchdog expired in COLLECT
oFRAME_CNT  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (iRST=1 at posedge): state=IDLE. All counters 0. Every output 0, including the sticky flags and oFRAME_CNT. Reset is honoured from any state and aborts an in-progress frame with no further writes.
- States: IDLE, LOAD, START, COLLECT, PAD, DONE.
- IDLE: iWRFULL=1 -> LOAD, rd_cnt=0. All other inputs are ignored.
- LOAD: oRDEN is combinational and equals (state==LOAD) & ~iRDEMPTY & (rd_cnt<iLEN). Each cycle with oRDEN=1 increments rd_cnt.
  - After the read that brings rd_cnt to iLEN -> START.
  - iRDEMPTY stalls reads without error.
- Row output timing: oROW_VALID, oROW_IDX and oROW_LAST are registered copies of oRDEN, rd_cnt and (rd_cnt==iLEN-1) at read issue. This gives 1-cycle FIFO latency.
- START: lasts one cycle, which is the cycle the last oROW_VALID is high. oBNN_START=1 is registered, so it appears in the first COLLECT cycle.
  - Timing: last oRDEN at cycle t -> last oROW_VALID at t+1 -> oBNN_START at t+2.
- COLLECT: res_cnt=0 and wd_cnt=0 on entry.
  - Each iRES_VALID=1 captures iRES_DATA and increments res_cnt. oWREN=1 and oDATA=captured word appear the next cycle.
  - When res_cnt reaches oLEN -> DONE.
  - iRES_VALID outside COLLECT is ignored. oWREN is never asserted for it.
- Watchdog: wd_cnt increments every COLLECT cycle and clears on each accepted iRES_VALID. At wd_cnt==TO_CYC-1 with no valid that cycle: oTIMEOUT<=1, -> PAD.
- PAD: writes 0 words (oWREN=1, oDATA=0), one per cycle, until oLEN total words are written, then -> DONE. The output FIFO always receives exactly oLEN words per frame.
- DONE: lasts one cycle. oFINISH=1 is registered and is high the cycle after DONE, which is 1 cycle after the last oWREN. oFRAME_CNT increments with oFINISH. Next state is IDLE.
  - If iWRFULL=1 in DONE -> LOAD directly (back-to-back frame, not overrun).
- Overrun: iWRFULL=1 in LOAD, START, COLLECT or PAD sets oOVERRUN. The current frame continues unaffected and the pulse is dropped.
- oDATA holds its last value when oWREN=0. It returns to 0 only on reset.
- Widths: counter compares are unsigned and zero-extended. No counter wraps inside a frame.

Test Plan:
- Nominal frame: iRDEMPTY=0, pulse iWRFULL.
  - Expect exactly 180 oRDEN cycles and oROW_IDX 0..179, with oROW_LAST only at 179.
  - Expect oBNN_START 2 cycles after the last oRDEN.
  - Feed 5 results 0x0001..0x0005 -> expect 5 oWREN with the same data in order, then oFINISH one cycle after the 5th write, oFRAME_CNT=1.
- FIFO stall: toggle iRDEMPTY randomly in LOAD -> expect oRDEN never high while iRDEMPTY=1, still exactly 180 rows, and indices contiguous.
- Overrun and back-to-back:
  - Pulse iWRFULL mid-LOAD -> expect oOVERRUN=1 and row count unchanged.
  - Pulse iWRFULL in the DONE cycle -> expect LOAD entered without overrun and a second frame completing with oFRAME_CNT=2.
- Timeout: TO_CYC=16, supply 2 results then none.
  - Expect oTIMEOUT=1 after 16 idle COLLECT cycles, then 3 oWREN writes with oDATA=0, then oFINISH.
- Reset mid-op: assert iRST during COLLECT after 3 results -> next cycle all outputs 0, state IDLE, no further oWREN. A fresh frame then runs nominally.
- Spurious inputs: iRES_VALID pulses in IDLE and LOAD -> no oWREN. oFRAME_CNT wraps 255->0 after 256 frames.
